// File: rtl/box_slot_manager_pkg.sv
// Shared types and helpers for the box slot manager: coordinate widths, box layout,
// collector FSM states and the box acceptance rule.
package box_pkg;

    localparam logic [11:0] H_ACT = 12'd1280;
    localparam logic [11:0] V_ACT = 12'd720;
    localparam int unsigned HW    = $clog2(H_ACT);
    localparam int unsigned VW    = $clog2(V_ACT);
    localparam int unsigned BOX_W = 2 * HW + 2 * VW + 24;

    // Field order matches the requester payload, MSB first.
    typedef struct packed {
        logic [HW-1:0] sx;
        logic [VW-1:0] sy;
        logic [HW-1:0] ex;
        logic [VW-1:0] ey;
        logic [23:0]   rgb;
    } box_t;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_COMMIT  = 1'b1
    } state_e;

    // All-zero coordinates are the downstream "no box" marker, so they are never stored.
    function automatic logic box_ok(input box_t b);
        logic inverted;
        logic empty;
        inverted = (b.sx > b.ex) || (b.sy > b.ey);
        empty    = (b.sx == '0) && (b.sy == '0) && (b.ex == '0) && (b.ey == '0);
        return !inverted && !empty;
    endfunction

endpackage

// File: rtl/box_slot_manager_if.sv
// Requester-side valid/ready handshake bundle for the box slot manager.
interface box_slot_manager_if
    import box_pkg::*;
#(
    parameter int unsigned N_REQ = 2
);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*BOX_W-1:0] req_box;

    modport master (output req_valid, output req_box, input req_ready);
    modport slave  (input req_valid, input req_box, output req_ready);

endinterface

// File: rtl/box_slot_manager_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among valid requesters, priority restarts
// just after the most recent grant.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt
);

    localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] mask, hi, src;
    logic             found;

    always_comb begin
        mask  = '0;
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            mask[i] = (PW'(i) >= ptr_q);
        end
        // Requests at or above the pointer win; otherwise wrap to the lowest index.
        hi  = req & mask;
        src = (|hi) ? hi : req;
        if (!en) begin
            src = '0;
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (src[i] && !found) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                ptr_d  = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr_q <= '0;
        end else if (|gnt) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/box_slot_manager.sv
// Collects boxes from several producers into a shadow slot array and commits it to the
// overlay slot buses once per frame. BOX_SLOT_HOLD_EN keeps the last set across empty frames.
module box_slot_manager
    import box_pkg::*;
#(
    parameter int unsigned N_BOX  = 4,
    parameter int unsigned N_REQ  = 2,
    parameter logic        VS_POL = 1'b1
`ifdef BOX_SLOT_HOLD_EN
    ,
    parameter int unsigned HOLD_FRAMES = 3
`endif
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_vsync,
    box_slot_manager_if.slave          req_if,
    output logic [N_BOX*HW-1:0]        start_xs,
    output logic [N_BOX*VW-1:0]        start_ys,
    output logic [N_BOX*HW-1:0]        end_xs,
    output logic [N_BOX*VW-1:0]        end_ys,
    output logic [N_BOX*24-1:0]        colors,
    output logic [$clog2(N_BOX+1)-1:0] box_count,
    output logic [7:0]                 drop_cnt,
    output logic                       commit_pulse
);

    localparam int unsigned    CW    = $clog2(N_BOX + 1);
    localparam logic [CW-1:0]  NBoxC = CW'(N_BOX);

    state_e           state_q;
    logic             vs_q;
    logic [CW-1:0]    wr_ptr_q;
    box_t             shadow_q [N_BOX];
    box_t             slot_q   [N_BOX];
    logic [N_REQ-1:0] gnt;
    box_t             in_box;
    logic             xfer;
    logic             store;
    logic             frame_edge;
    logic             hold;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .clk  (clk),
        .rstn (rstn),
        .en   (state_q == S_COLLECT),
        .req  (req_if.req_valid),
        .gnt  (gnt)
    );

    assign req_if.req_ready = gnt;

    always_comb begin
        in_box = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                in_box = box_t'(req_if.req_box[i*BOX_W +: BOX_W]);
            end
        end
    end

    assign xfer       = |gnt;
    assign store      = box_ok(in_box) && (wr_ptr_q != NBoxC);
    assign frame_edge = (i_vsync == VS_POL) && (vs_q != VS_POL);

`ifdef BOX_SLOT_HOLD_EN
    localparam int unsigned   HCW   = $clog2(HOLD_FRAMES + 1);
    localparam logic [HCW-1:0] HoldC = HCW'(HOLD_FRAMES);

    logic [HCW-1:0] hold_cnt_q;

    // Empty commits keep the previous set until the hold budget is used up.
    assign hold = (wr_ptr_q == '0) && (hold_cnt_q != HoldC);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt_q <= '0;
        end else if (state_q == S_COMMIT) begin
            if (hold) begin
                hold_cnt_q <= hold_cnt_q + 1'b1;
            end else if (wr_ptr_q != '0) begin
                hold_cnt_q <= '0;
            end
        end
    end
`else
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_COLLECT;
            vs_q         <= ~VS_POL;
            wr_ptr_q     <= '0;
            box_count    <= '0;
            drop_cnt     <= '0;
            commit_pulse <= 1'b0;
            for (int i = 0; i < N_BOX; i++) begin
                shadow_q[i] <= '0;
                slot_q[i]   <= '0;
            end
        end else begin
            vs_q         <= i_vsync;
            commit_pulse <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (xfer) begin
                        if (store) begin
                            for (int i = 0; i < N_BOX; i++) begin
                                if (wr_ptr_q == CW'(i)) begin
                                    shadow_q[i] <= in_box;
                                end
                            end
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                        end else if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                    if (frame_edge) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    commit_pulse <= 1'b1;
                    if (!hold) begin
                        for (int i = 0; i < N_BOX; i++) begin
                            slot_q[i] <= (CW'(i) < wr_ptr_q) ? shadow_q[i] : '0;
                        end
                        box_count <= wr_ptr_q;
                    end
                    for (int i = 0; i < N_BOX; i++) begin
                        shadow_q[i] <= '0;
                    end
                    wr_ptr_q <= '0;
                    state_q  <= S_COLLECT;
                end
                default: state_q <= S_COLLECT;
            endcase
        end
    end

    always_comb begin
        start_xs = '0;
        start_ys = '0;
        end_xs   = '0;
        end_ys   = '0;
        colors   = '0;
        for (int i = 0; i < N_BOX; i++) begin
            start_xs[i*HW +: HW] = slot_q[i].sx;
            start_ys[i*VW +: VW] = slot_q[i].sy;
            end_xs[i*HW +: HW]   = slot_q[i].ex;
            end_ys[i*VW +: VW]   = slot_q[i].ey;
            colors[i*24 +: 24]   = slot_q[i].rgb;
        end
    end

endmodule

// File: tb/tb_box_slot_manager.sv
// Scoreboard bench for box_slot_manager: stimulus queues expected commits, a monitor
// compares them whenever commit_pulse fires.
module tb_box_slot_manager;
    import box_pkg::*;

    localparam int unsigned N_BOX = 4;
    localparam int unsigned N_REQ = 2;

    typedef struct packed {
        logic [2:0]      cnt;
        logic [7:0]      drop;
        box_t [3:0]      s;
    } exp_t;

    logic                       clk;
    logic                       rstn;
    logic                       i_vsync;
    logic [N_BOX*HW-1:0]        start_xs;
    logic [N_BOX*VW-1:0]        start_ys;
    logic [N_BOX*HW-1:0]        end_xs;
    logic [N_BOX*VW-1:0]        end_ys;
    logic [N_BOX*24-1:0]        colors;
    logic [2:0]                 box_count;
    logic [7:0]                 drop_cnt;
    logic                       commit_pulse;

    box_slot_manager_if #(.N_REQ(N_REQ)) tbif ();

    box_slot_manager #(
        .N_BOX  (N_BOX),
        .N_REQ  (N_REQ),
        .VS_POL (1'b1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_vsync      (i_vsync),
        .req_if       (tbif.slave),
        .start_xs     (start_xs),
        .start_ys     (start_ys),
        .end_xs       (end_xs),
        .end_ys       (end_ys),
        .colors       (colors),
        .box_count    (box_count),
        .drop_cnt     (drop_cnt),
        .commit_pulse (commit_pulse)
    );

    int   total  = 0;
    int   passed = 0;
    int   pulses = 0;
    int   pushed = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    box_t mon_act;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    function automatic box_t mk(input int sx, input int sy, input int ex, input int ey,
                                input logic [23:0] c);
        box_t b;
        b.sx  = HW'(sx);
        b.sy  = VW'(sy);
        b.ex  = HW'(ex);
        b.ey  = VW'(ey);
        b.rgb = c;
        return b;
    endfunction

    task automatic push(input int cnt, input int drop, input box_t s0, input box_t s1,
                        input box_t s2, input box_t s3);
        exp_t e;
        e.cnt  = 3'(cnt);
        e.drop = 8'(drop);
        e.s[0] = s0;
        e.s[1] = s1;
        e.s[2] = s2;
        e.s[3] = s3;
        exp_q.push_back(e);
        pushed++;
    endtask

    // Offer one box and wait (bounded) for its grant; returns cycles waited.
    task automatic send(input int r, input box_t b, output int n);
        tbif.req_box[r*BOX_W +: BOX_W] = b;
        tbif.req_valid[r] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tbif.req_ready[r] && n < 20);
        if (!tbif.req_ready[r]) chk("send_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
        tbif.req_valid[r] = 1'b0;
    endtask

    task automatic frame_edge();
        i_vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("commit_ready_low", 128'(tbif.req_ready), 128'(0));
        chk("pulse_not_early", 128'(commit_pulse), 128'(0));
        @(negedge clk);
        chk("pulse_at_t2", 128'(commit_pulse), 128'(1));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        i_vsync = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && commit_pulse) begin
            pulses++;
            chk("commit_pending", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("box_count", 128'(box_count), 128'(mon_e.cnt));
                chk("drop_cnt", 128'(drop_cnt), 128'(mon_e.drop));
                for (int i = 0; i < 4; i++) begin
                    mon_act = {start_xs[i*HW +: HW], start_ys[i*VW +: VW], end_xs[i*HW +: HW],
                               end_ys[i*VW +: VW], colors[i*24 +: 24]};
                    chk($sformatf("slot%0d", i), 128'(mon_act), 128'(mon_e.s[i]));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        box_t z, a[2], b[2], p, inv, c1, c2, d, e1, f1;
        int   n, ia, ib;
        logic [1:0] exp_g;

        z    = '0;
        a[0] = mk(10, 20, 30, 40, 24'h112233);
        b[0] = mk(11, 21, 31, 41, 24'h445566);
        a[1] = mk(12, 22, 32, 42, 24'h778899);
        b[1] = mk(13, 23, 33, 43, 24'hAABBCC);
        p    = mk(100, 50, 200, 150, 24'hFF0000);
        c1   = mk(400, 300, 500, 310, 24'h00FF00);
        c2   = mk(7, 8, 9, 10, 24'h0000FF);
        d    = mk(600, 100, 1000, 700, 24'h123456);
        e1   = mk(5, 5, 6, 6, 24'hABCDEF);
        f1   = mk(15, 15, 16, 16, 24'hFEDCBA);

        rstn = 1'b0;
        i_vsync = 1'b0;
        tbif.req_valid = '0;
        tbif.req_box = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_box_count", 128'(box_count), 128'(0));
        chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
        chk("rst_pulse", 128'(commit_pulse), 128'(0));
        chk("rst_slots", 128'({start_xs, end_ys, colors}), 128'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both requesters always valid, grants must alternate from 0.
        ia = 0;
        ib = 0;
        for (int k = 0; k < 4; k++) begin
            tbif.req_valid = 2'b11;
            tbif.req_box[0 +: BOX_W] = a[(ia > 1) ? 1 : ia];
            tbif.req_box[BOX_W +: BOX_W] = b[(ib > 1) ? 1 : ib];
            @(negedge clk);
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_grant", 128'(tbif.req_ready), 128'(exp_g));
            if (tbif.req_ready[0]) ia++;
            if (tbif.req_ready[1]) ib++;
            @(posedge clk);
            #1;
        end
        tbif.req_valid = '0;
        push(4, 0, a[0], b[0], a[1], b[1]);
        frame_edge();

        // Single box.
        send(0, p, n);
        push(1, 0, p, z, z, z);
        frame_edge();

        // Rejections: inverted x, all-zero, inverted y; then a one-pixel box that is kept.
        send(0, mk(300, 10, 200, 20, 24'h00FF00), n);
        chk("invalid_ready", 128'(n), 128'(1));
        send(0, mk(0, 0, 0, 0, 24'h111111), n);
        send(0, mk(5, 30, 10, 20, 24'h222222), n);
        send(0, mk(1, 1, 1, 1, 24'h010203), n);
        chk("drop_invalid", 128'(drop_cnt), 128'(3));
        push(1, 3, mk(1, 1, 1, 1, 24'h010203), z, z, z);
        frame_edge();

        // Overflow: six boxes into four slots.
        for (int k = 0; k < 6; k++) begin
            send(0, mk(k + 1, k + 2, k + 3, k + 4, 24'(k)), n);
        end
        chk("drop_overflow", 128'(drop_cnt), 128'(5));
        push(4, 5, mk(1, 2, 3, 4, 24'd0), mk(2, 3, 4, 5, 24'd1), mk(3, 4, 5, 6, 24'd2),
             mk(4, 5, 6, 7, 24'd3));
        frame_edge();

        // Transfer in the edge cycle lands in this commit; ready drops for the commit cycle.
        i_vsync = 1'b1;
        tbif.req_valid[1] = 1'b1;
        tbif.req_box[BOX_W +: BOX_W] = c1;
        push(1, 5, c1, z, z, z);
        @(negedge clk);
        chk("edge_cycle_ready", 128'(tbif.req_ready), 128'(2'b10));
        @(posedge clk);
        #1;
        tbif.req_box[BOX_W +: BOX_W] = c2;
        @(negedge clk);
        chk("ready_after_edge", 128'(tbif.req_ready), 128'(0));
        @(negedge clk);
        chk("ready_resumes", 128'(tbif.req_ready), 128'(2'b10));
        chk("edge_pulse_t2", 128'(commit_pulse), 128'(1));
        @(posedge clk);
        #1;
        tbif.req_valid = '0;
        i_vsync = 1'b0;
        send(0, d, n);
        push(2, 5, c2, d, z, z);
        frame_edge();

        // Four empty frames.
`ifdef BOX_SLOT_HOLD_EN
        for (int k = 0; k < 3; k++) push(2, 5, c2, d, z, z);
        push(0, 5, z, z, z, z);
`else
        for (int k = 0; k < 4; k++) push(0, 5, z, z, z, z);
`endif
        for (int k = 0; k < 4; k++) frame_edge();

        // Drop counter saturation: 260 invalid boxes back to back.
        tbif.req_box[0 +: BOX_W] = mk(9, 9, 1, 1, 24'h333333);
        tbif.req_valid[0] = 1'b1;
        repeat (260) @(posedge clk);
        #1;
        tbif.req_valid = '0;
        chk("drop_sat", 128'(drop_cnt), 128'(255));
        send(0, e1, n);
        push(1, 255, e1, z, z, z);
        frame_edge();

        // Reset mid-frame clears committed set, counter and pending shadow contents.
        send(1, f1, n);
        rstn = 1'b0;
        #1;
        chk("midrst_count", 128'(box_count), 128'(0));
        chk("midrst_drop", 128'(drop_cnt), 128'(0));
        chk("midrst_slots", 128'({start_xs, colors}), 128'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        push(0, 0, z, z, z, z);
        frame_edge();

        repeat (3) @(posedge clk);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        chk("pulse_total", 128'(pulses), 128'(pushed));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
